// File: rtl/branch_predictor_param_if.sv
// branch_predictor_param_if: fetch/decode bus between the pipeline and the
// branch predictor.
//   slave  modport : the predictor (consumes stall/fetch/decode info,
//                    drives prediction and mispredict redirect)
//   master modport : the pipeline side (the opposite directions)
// Signals:
//   stall                   pipeline hazard stall
//   fetch_pc                byte PC in fetch
//   pred_sel / pred_target  fetch redirect request and target
//   dec_pc, dec_is_branch, dec_is_jump, dec_taken, dec_target
//                           resolved decode-stage control flow
//   mispred_sel / mispred_target
//                           decode redirect and corrected PC
//   perf_resolved / perf_mispred
//                           32-bit event counters, present only when
//                           BRANCH_PREDICTOR_PERF_CNT_EN is defined
interface branch_predictor_param_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              stall;
  logic [ADDR_W-1:0] fetch_pc;
  logic              pred_sel;
  logic [ADDR_W-1:0] pred_target;
  logic [ADDR_W-1:0] dec_pc;
  logic              dec_is_branch;
  logic              dec_is_jump;
  logic              dec_taken;
  logic [ADDR_W-1:0] dec_target;
  logic              mispred_sel;
  logic [ADDR_W-1:0] mispred_target;
`ifdef BRANCH_PREDICTOR_PERF_CNT_EN
  logic [31:0]       perf_resolved;
  logic [31:0]       perf_mispred;

  modport slave (
    input  stall, fetch_pc, dec_pc, dec_is_branch, dec_is_jump, dec_taken, dec_target,
    output pred_sel, pred_target, mispred_sel, mispred_target, perf_resolved, perf_mispred
  );
  modport master (
    output stall, fetch_pc, dec_pc, dec_is_branch, dec_is_jump, dec_taken, dec_target,
    input  pred_sel, pred_target, mispred_sel, mispred_target, perf_resolved, perf_mispred
  );
`else
  modport slave (
    input  stall, fetch_pc, dec_pc, dec_is_branch, dec_is_jump, dec_taken, dec_target,
    output pred_sel, pred_target, mispred_sel, mispred_target
  );
  modport master (
    output stall, fetch_pc, dec_pc, dec_is_branch, dec_is_jump, dec_taken, dec_target,
    input  pred_sel, pred_target, mispred_sel, mispred_target
  );
`endif
endinterface

// File: rtl/branch_predictor_param.sv
// branch_predictor_param: direct-mapped branch target buffer with saturating
// direction counters, a fetch/decode prediction register, and decode-stage
// mispredict detection / table update.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   io_bp  branch_predictor_param_if.slave bus (see interface header)
// Parameters:
//   ADDR_W      PC/target width
//   INDEX_BITS  BTB index width (2**INDEX_BITS entries)
//   TAG_BITS    stored tag width (INDEX_BITS+TAG_BITS+2 <= ADDR_W)
//   CTR_BITS    direction counter width (>= 1); MSB set means predict taken
// Optional feature: define BRANCH_PREDICTOR_PERF_CNT_EN to add the
// perf_resolved / perf_mispred event counters.
module branch_predictor_param #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned TAG_BITS   = 24,
  parameter int unsigned CTR_BITS   = 2
) (
  input logic                     clk,
  input logic                     rst_n,
  branch_predictor_param_if.slave io_bp
);

  localparam int unsigned DEPTH = 1 << INDEX_BITS;
  localparam int unsigned TAG_LO = INDEX_BITS + 2;
  localparam int unsigned TAG_HI = INDEX_BITS + TAG_BITS + 1;

  localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_ONE << (CTR_BITS - 1);

  // BTB storage
  logic                r_valid  [DEPTH];
  logic [TAG_BITS-1:0] r_tag    [DEPTH];
  logic [ADDR_W-1:0]   r_target [DEPTH];
  logic [CTR_BITS-1:0] r_ctr    [DEPTH];

  // Fetch/decode prediction register
  logic                r_p_hit;
  logic                r_p_taken;
  logic [ADDR_W-1:0]   r_p_target;
  logic [CTR_BITS-1:0] r_p_ctr;

  // Fetch lookup
  logic [INDEX_BITS-1:0] w_f_idx;
  logic [TAG_BITS-1:0]   w_f_tag;
  logic                  w_f_hit;
  logic                  w_f_taken;

  assign w_f_idx   = io_bp.fetch_pc[INDEX_BITS+1:2];
  assign w_f_tag   = io_bp.fetch_pc[TAG_HI:TAG_LO];
  assign w_f_hit   = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign w_f_taken = w_f_hit && r_ctr[w_f_idx][CTR_BITS-1];

  assign io_bp.pred_sel    = w_f_taken && !io_bp.stall;
  assign io_bp.pred_target = io_bp.pred_sel ? r_target[w_f_idx] : '0;

  // Decode resolution. Gating with rst_n keeps the redirect quiet while reset
  // is held even if decode inputs still show a branch.
  logic                  w_res;
  logic                  w_act_taken;
  logic                  w_mispred;
  logic [INDEX_BITS-1:0] w_d_idx;
  logic [TAG_BITS-1:0]   w_d_tag;

  assign w_res       = (io_bp.dec_is_branch || io_bp.dec_is_jump) && !io_bp.stall && rst_n;
  assign w_act_taken = io_bp.dec_is_jump || io_bp.dec_taken;
  assign w_mispred   = w_res && ((w_act_taken != r_p_taken) ||
                                 (w_act_taken && r_p_taken && (io_bp.dec_target != r_p_target)));
  assign w_d_idx     = io_bp.dec_pc[INDEX_BITS+1:2];
  assign w_d_tag     = io_bp.dec_pc[TAG_HI:TAG_LO];

  assign io_bp.mispred_sel    = w_mispred;
  assign io_bp.mispred_target = !w_mispred ? '0 :
                                w_act_taken ? io_bp.dec_target :
                                (io_bp.dec_pc + ADDR_W'(4));

  // BTB write decision. Counter updates use the counter captured with the
  // prediction, so the table is not re-read in decode.
  logic                w_we_alloc;
  logic                w_we_tgt;
  logic                w_we_ctr;
  logic [CTR_BITS-1:0] w_new_ctr;

  always_comb begin
    w_we_alloc = 1'b0;
    w_we_tgt   = 1'b0;
    w_we_ctr   = 1'b0;
    w_new_ctr  = r_p_ctr;
    if (w_res) begin
      if (io_bp.dec_is_jump) begin
        // Jumps (including branch+jump) always allocate/refresh as strongly taken
        w_we_alloc = 1'b1;
        w_we_tgt   = 1'b1;
        w_we_ctr   = 1'b1;
        w_new_ctr  = CTR_MAX;
      end else if (r_p_hit) begin
        w_we_ctr = 1'b1;
        w_we_tgt = io_bp.dec_taken;
        if (io_bp.dec_taken) begin
          w_new_ctr = (r_p_ctr == CTR_MAX) ? r_p_ctr : (r_p_ctr + CTR_ONE);
        end else begin
          w_new_ctr = (r_p_ctr == '0) ? r_p_ctr : (r_p_ctr - CTR_ONE);
        end
      end else if (io_bp.dec_taken) begin
        w_we_alloc = 1'b1;
        w_we_tgt   = 1'b1;
        w_we_ctr   = 1'b1;
        w_new_ctr  = CTR_WEAK;
      end
    end
  end

  // Writes land at the edge, so a same-cycle fetch of this index sees old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= '0;
      end
    end else begin
      if (w_we_alloc) begin
        r_valid[w_d_idx] <= 1'b1;
        r_tag[w_d_idx]   <= w_d_tag;
      end
      if (w_we_tgt) begin
        r_target[w_d_idx] <= io_bp.dec_target;
      end
      if (w_we_ctr) begin
        r_ctr[w_d_idx] <= w_new_ctr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_hit    <= 1'b0;
      r_p_taken  <= 1'b0;
      r_p_target <= '0;
      r_p_ctr    <= '0;
    end else if (!io_bp.stall) begin
      if (w_mispred) begin
        // The instruction in fetch is being flushed
        r_p_hit    <= 1'b0;
        r_p_taken  <= 1'b0;
        r_p_target <= '0;
        r_p_ctr    <= '0;
      end else begin
        r_p_hit    <= w_f_hit;
        r_p_taken  <= w_f_taken;
        r_p_target <= r_target[w_f_idx];
        r_p_ctr    <= r_ctr[w_f_idx];
      end
    end
  end

`ifdef BRANCH_PREDICTOR_PERF_CNT_EN
  logic [31:0] r_perf_resolved;
  logic [31:0] r_perf_mispred;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_resolved <= '0;
      r_perf_mispred  <= '0;
    end else begin
      if (w_res) begin
        r_perf_resolved <= r_perf_resolved + 32'd1;
      end
      if (w_mispred) begin
        r_perf_mispred <= r_perf_mispred + 32'd1;
      end
    end
  end

  assign io_bp.perf_resolved = r_perf_resolved;
  assign io_bp.perf_mispred  = r_perf_mispred;
`endif

  // PC bits that never reach the table (byte offset, and any bits above the tag)
  logic w_unused_fetch_lo;
  assign w_unused_fetch_lo = ^io_bp.fetch_pc[1:0];

  if (TAG_HI + 1 < ADDR_W) begin : g_unused_hi
    logic w_unused_fetch_hi;
    assign w_unused_fetch_hi = ^io_bp.fetch_pc[ADDR_W-1:TAG_HI+1];
  end

endmodule

// File: tb/tb_branch_predictor_param.sv
module tb_branch_predictor_param;

  logic clk;
  logic rst_n;

  branch_predictor_param_if #(.ADDR_W(32)) bp ();

  branch_predictor_param #(
    .ADDR_W    (32),
    .INDEX_BITS(6),
    .TAG_BITS  (24),
    .CTR_BITS  (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io_bp(bp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [31:0] fpc;
    logic        br;
    logic        jmp;
    logic        tk;
    logic [31:0] dpc;
    logic [31:0] dtgt;
    logic        e_ps;
    logic [31:0] e_pt;
    logic        e_ms;
    logic [31:0] e_mt;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_res   = 0;
  int   n_mis   = 0;

  localparam logic [31:0] F = 32'h0000_00FC;  // index 63, never allocated with tag 0

  task automatic v(input logic st, input logic [31:0] fpc, input logic br, input logic jmp,
                   input logic tk, input logic [31:0] dpc, input logic [31:0] dtgt,
                   input logic eps, input logic [31:0] ept, input logic ems,
                   input logic [31:0] emt);
    vec_t r;
    r.stall = st; r.fpc = fpc; r.br = br; r.jmp = jmp; r.tk = tk; r.dpc = dpc;
    r.dtgt = dtgt; r.e_ps = eps; r.e_pt = ept; r.e_ms = ems; r.e_mt = emt;
    vecs.push_back(r);
  endtask

  // fetch-only cycle
  task automatic f(input logic [31:0] fpc, input logic eps, input logic [31:0] ept);
    v(1'b0, fpc, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, eps, ept, 1'b0, 32'h0);
  endtask

  task automatic chk(input string nm, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    bp.stall         = r.stall;
    bp.fetch_pc      = r.fpc;
    bp.dec_is_branch = r.br;
    bp.dec_is_jump   = r.jmp;
    bp.dec_taken     = r.tk;
    bp.dec_pc        = r.dpc;
    bp.dec_target    = r.dtgt;
  endtask

  task automatic idle(input logic [31:0] fpc);
    vec_t r;
    r.stall = 1'b0; r.fpc = fpc; r.br = 1'b0; r.jmp = 1'b0; r.tk = 1'b0;
    r.dpc = '0; r.dtgt = '0; r.e_ps = 1'b0; r.e_pt = '0; r.e_ms = 1'b0; r.e_mt = '0;
    drive(r);
  endtask

  initial begin
    vec_t cur;
    vec_t e;

    // Allocation / training at 0x40 (row 1 fetch collides with the write)
    f(32'h40, 0, 32'h0);
    v(0, 32'h40, 1, 0, 1, 32'h40, 32'h80, 0, 32'h0, 1, 32'h80);
    f(32'h40, 1, 32'h80);
    v(0, F, 1, 0, 1, 32'h40, 32'h80, 0, 32'h0, 0, 32'h0);
    f(32'h40, 1, 32'h80);
    v(0, F, 1, 0, 0, 32'h40, 32'h0, 0, 32'h0, 1, 32'h44);
    f(32'h40, 1, 32'h80);
    v(0, F, 1, 0, 0, 32'h40, 32'h0, 0, 32'h0, 1, 32'h44);
    f(32'h40, 0, 32'h0);
    // 0x100: train to 11, then not-taken down to saturated 00, then taken
    f(32'h100, 0, 32'h0);
    v(0, F, 1, 0, 1, 32'h100, 32'h200, 0, 32'h0, 1, 32'h200);
    f(32'h100, 1, 32'h200);
    v(0, F, 1, 0, 1, 32'h100, 32'h200, 0, 32'h0, 0, 32'h0);
    f(32'h100, 1, 32'h200);
    v(0, F, 1, 0, 0, 32'h100, 32'h0, 0, 32'h0, 1, 32'h104);
    f(32'h100, 1, 32'h200);
    v(0, F, 1, 0, 0, 32'h100, 32'h0, 0, 32'h0, 1, 32'h104);
    f(32'h100, 0, 32'h0);
    v(0, F, 1, 0, 0, 32'h100, 32'h0, 0, 32'h0, 0, 32'h0);
    f(32'h100, 0, 32'h0);
    v(0, F, 1, 0, 0, 32'h100, 32'h0, 0, 32'h0, 0, 32'h0);
    f(32'h100, 0, 32'h0);
    v(0, F, 1, 0, 1, 32'h100, 32'h200, 0, 32'h0, 1, 32'h200);
    // Aliasing: 0x1100 shares index 0 with 0x100
    f(32'h1100, 0, 32'h0);
    v(0, 32'h1100, 1, 0, 1, 32'h1100, 32'h400, 0, 32'h0, 1, 32'h400);
    f(32'h100, 0, 32'h0);
    f(32'h1100, 1, 32'h400);
    // Stall for 3 cycles with a jump in decode: no redirect, no write, hold
    v(1, 32'h1100, 0, 1, 0, 32'h80, 32'h500, 0, 32'h0, 0, 32'h0);
    v(1, F, 0, 1, 0, 32'h80, 32'h500, 0, 32'h0, 0, 32'h0);
    v(1, F, 0, 1, 0, 32'h80, 32'h500, 0, 32'h0, 0, 32'h0);
    v(0, F, 1, 0, 1, 32'h1100, 32'h400, 0, 32'h0, 0, 32'h0);
    f(32'h80, 0, 32'h0);
    f(32'h1100, 1, 32'h400);
    // Jump 0x20 -> 0x300, then target moves to 0x340; then branch+jump
    f(32'h20, 0, 32'h0);
    v(0, F, 0, 1, 0, 32'h20, 32'h300, 0, 32'h0, 1, 32'h300);
    f(32'h20, 1, 32'h300);
    v(0, F, 0, 1, 0, 32'h20, 32'h340, 0, 32'h0, 1, 32'h340);
    f(32'h20, 1, 32'h340);
    v(0, F, 1, 1, 0, 32'h20, 32'h340, 0, 32'h0, 0, 32'h0);
    f(32'h20, 1, 32'h340);
    // Fall-through wraps at the top of the address space
    f(32'hFFFF_FFFC, 0, 32'h0);
    v(0, F, 1, 0, 1, 32'hFFFF_FFFC, 32'h10, 0, 32'h0, 1, 32'h10);
    f(32'hFFFF_FFFC, 1, 32'h10);
    v(0, F, 1, 0, 0, 32'hFFFF_FFFC, 32'h0, 0, 32'h0, 1, 32'h0);

    rst_n = 1'b0;
    idle(32'h40);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pred_sel", -1, {31'b0, bp.pred_sel}, 32'h0);
    chk("reset_pred_target", -1, bp.pred_target, 32'h0);
    chk("reset_mispred_sel", -1, {31'b0, bp.mispred_sel}, 32'h0);
    chk("reset_mispred_target", -1, bp.mispred_target, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      cur = vecs[i];
      drive(cur);
      exp_q.push_back(cur);
      if ((cur.br || cur.jmp) && !cur.stall) n_res++;
      if (cur.e_ms) n_mis++;
      @(negedge clk);
      e = exp_q.pop_front();
      chk("pred_sel", i, {31'b0, bp.pred_sel}, {31'b0, e.e_ps});
      chk("pred_target", i, bp.pred_target, e.e_pt);
      chk("mispred_sel", i, {31'b0, bp.mispred_sel}, {31'b0, e.e_ms});
      chk("mispred_target", i, bp.mispred_target, e.e_mt);
    end

    // Jump at 0x20 still predicted to 0x340
    @(posedge clk);
    #1;
    idle(32'h20);
    @(negedge clk);
    chk("seq_pred_sel_0x20", -1, {31'b0, bp.pred_sel}, 32'h1);
    chk("seq_pred_target_0x20", -1, bp.pred_target, 32'h340);
`ifdef BRANCH_PREDICTOR_PERF_CNT_EN
    chk("perf_resolved", -1, bp.perf_resolved, n_res);
    chk("perf_mispred", -1, bp.perf_mispred, n_mis);
`endif

    // Asynchronous reset mid-cycle with a mispredicting jump in decode
    @(posedge clk);
    #1;
    bp.dec_is_jump = 1'b1;
    bp.dec_pc      = 32'h20;
    bp.dec_target  = 32'h999;
    #1;
    chk("seq_pre_reset_mispred", -1, {31'b0, bp.mispred_sel}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_pred_sel", -1, {31'b0, bp.pred_sel}, 32'h0);
    chk("async_pred_target", -1, bp.pred_target, 32'h0);
    chk("async_mispred_sel", -1, {31'b0, bp.mispred_sel}, 32'h0);
    chk("async_mispred_target", -1, bp.mispred_target, 32'h0);
`ifdef BRANCH_PREDICTOR_PERF_CNT_EN
    chk("async_perf_resolved", -1, bp.perf_resolved, 32'h0);
`endif
    @(posedge clk);
    @(negedge clk);
    idle(32'h20);
    rst_n = 1'b1;
    #1;
    chk("post_reset_pred_sel", -1, {31'b0, bp.pred_sel}, 32'h0);
    chk("post_reset_mispred_sel", -1, {31'b0, bp.mispred_sel}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("post_reset_miss_0x20", -1, {31'b0, bp.pred_sel}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
